// File: rtl/change_dispenser.sv
// Change payout stage: pays a latched amount greedily as one coin pulse per clock,
// bounded by per-denomination inventories, and reports any unpaid residue.
module change_dispenser #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned INV_W     = 8,
  parameter int unsigned INIT_1000 = 20,
  parameter int unsigned INIT_500  = 20,
  parameter int unsigned INIT_100  = 50,
  parameter int unsigned INIT_50   = 50
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_CHANGE,
  input  logic             IN_LOAD,
  input  logic             IN_REFILL,
  output logic             OUT_1000WON,
  output logic             OUT_500WON,
  output logic             OUT_100WON,
  output logic             OUT_50WON,
  output logic             OUT_BUSY,
  output logic             OUT_DONE,
  output logic             OUT_SHORT,
  output logic [WIDTH-1:0] OUT_REMAIN,
  output logic [3:0]       OUT_INV_EMPTY
);

  typedef enum logic [0:0] {StIdle, StDispense} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [3:0][INV_W-1:0]  inv_q, inv_d;
  logic [3:0]             coin_q, coin_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   short_q, short_d;
  logic [3:0]             empty_q, empty_d, empty_init;

  logic [3:0][INV_W-1:0]  inv_init;
  logic [3:0][WIDTH-1:0]  denom;
  logic [3:0]             eligible;
  logic [3:0]             pick;
  logic [WIDTH-1:0]       change_val;

  // Index 0 is the largest denomination, so lowest set bit = highest priority.
  assign inv_init = {INV_W'(INIT_50), INV_W'(INIT_100), INV_W'(INIT_500), INV_W'(INIT_1000)};
  assign denom    = {WIDTH'(50), WIDTH'(100), WIDTH'(500), WIDTH'(1000)};

  // IN_CHANGE carries its MSB on bit 0; reverse into natural order.
  assign change_val = {<<{IN_CHANGE}};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i]   = (rem_q >= denom[i]) && (inv_q[i] != '0);
      empty_init[i] = (inv_init[i] == '0);
    end
    pick = eligible & ~(eligible - 4'd1);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    inv_d   = inv_q;
    coin_d  = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    short_d = short_q;
    unique case (state_q)
      StIdle: begin
        // Refill takes effect before a simultaneous load starts paying.
        if (IN_REFILL) inv_d = inv_init;
        if (IN_LOAD) begin
          rem_d   = change_val;
          short_d = 1'b0;
          busy_d  = 1'b1;
          state_d = StDispense;
        end
      end
      StDispense: begin
        if (eligible != '0) begin
          coin_d = pick;
          for (int i = 0; i < 4; i++) begin
            if (pick[i]) begin
              rem_d    = rem_q - denom[i];
              inv_d[i] = inv_q[i] - INV_W'(1);
            end
          end
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          short_d = (rem_q != '0);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    for (int i = 0; i < 4; i++) empty_d[i] = (inv_d[i] == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rem_q   <= '0;
      inv_q   <= inv_init;
      coin_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      empty_q <= empty_init;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      inv_q   <= inv_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      short_q <= short_d;
      empty_q <= empty_d;
    end
  end

  assign OUT_1000WON   = coin_q[0];
  assign OUT_500WON    = coin_q[1];
  assign OUT_100WON    = coin_q[2];
  assign OUT_50WON     = coin_q[3];
  assign OUT_BUSY      = busy_q;
  assign OUT_DONE      = done_q;
  assign OUT_SHORT     = short_q;
  assign OUT_REMAIN    = rem_q;
  assign OUT_INV_EMPTY = empty_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: three instances (default, no 500s, two 50s),
// a greedy reference model queues expected per-cycle outputs for each payout.
module tb_change_dispenser;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [W-1:0]        chg;
  logic [2:0]          load, refill;
  logic [2:0][3:0]     coin;
  logic [2:0]          busy, done, shrt;
  logic [2:0][W-1:0]   remain;
  logic [2:0][3:0]     empty;

  change_dispenser #(.WIDTH(W)) dut_a (
    .CLK(clk), .RST(rst), .IN_CHANGE(chg), .IN_LOAD(load[0]), .IN_REFILL(refill[0]),
    .OUT_1000WON(coin[0][0]), .OUT_500WON(coin[0][1]), .OUT_100WON(coin[0][2]),
    .OUT_50WON(coin[0][3]), .OUT_BUSY(busy[0]), .OUT_DONE(done[0]), .OUT_SHORT(shrt[0]),
    .OUT_REMAIN(remain[0]), .OUT_INV_EMPTY(empty[0])
  );

  change_dispenser #(.WIDTH(W), .INIT_500(0)) dut_b (
    .CLK(clk), .RST(rst), .IN_CHANGE(chg), .IN_LOAD(load[1]), .IN_REFILL(refill[1]),
    .OUT_1000WON(coin[1][0]), .OUT_500WON(coin[1][1]), .OUT_100WON(coin[1][2]),
    .OUT_50WON(coin[1][3]), .OUT_BUSY(busy[1]), .OUT_DONE(done[1]), .OUT_SHORT(shrt[1]),
    .OUT_REMAIN(remain[1]), .OUT_INV_EMPTY(empty[1])
  );

  change_dispenser #(.WIDTH(W), .INIT_50(2)) dut_c (
    .CLK(clk), .RST(rst), .IN_CHANGE(chg), .IN_LOAD(load[2]), .IN_REFILL(refill[2]),
    .OUT_1000WON(coin[2][0]), .OUT_500WON(coin[2][1]), .OUT_100WON(coin[2][2]),
    .OUT_50WON(coin[2][3]), .OUT_BUSY(busy[2]), .OUT_DONE(done[2]), .OUT_SHORT(shrt[2]),
    .OUT_REMAIN(remain[2]), .OUT_INV_EMPTY(empty[2])
  );

  typedef struct packed {
    logic [3:0]   coin;
    logic         busy;
    logic         done;
    logic         shrt;
    logic [W-1:0] rem;
    logic [3:0]   empty;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   minv [3][4];
  int   initv [3][4] = '{'{20, 20, 50, 50}, '{20, 0, 50, 50}, '{20, 20, 50, 2}};
  int   den [4] = '{1000, 500, 100, 50};

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) minv[i][j] = initv[i][j];
  endtask

  function automatic logic [3:0] model_empty(input int i);
    logic [3:0] e;
    for (int j = 0; j < 4; j++) e[j] = (minv[i][j] == 0);
    return e;
  endfunction

  // Greedy reference: one expected entry per cycle from k+1 through DONE.
  task automatic plan(input int i, input int amt);
    int r = amt;
    int sel;
    exp_t e;
    forever begin
      sel = -1;
      for (int j = 3; j >= 0; j--) if (r >= den[j] && minv[i][j] > 0) sel = j;
      if (sel < 0) begin
        e.coin = '0; e.busy = 1'b0; e.done = 1'b1; e.shrt = (r != 0);
        e.rem = W'(r); e.empty = model_empty(i);
        exp_q.push_back(e);
        break;
      end
      r -= den[sel];
      minv[i][sel]--;
      e.coin = 4'(1 << sel); e.busy = 1'b1; e.done = 1'b0; e.shrt = 1'b0;
      e.rem = W'(r); e.empty = model_empty(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_payout(input int i, input int amt, input bit poke, input bit with_refill,
                            output int done_at);
    logic [W-1:0] a16;
    exp_t e;
    int cyc = 0;
    a16 = W'(amt);
    done_at = -1;
    @(negedge clk);
    chg = {<<{a16}};
    load[i] = 1'b1;
    refill[i] = with_refill;
    @(posedge clk); #1;
    load[i] = 1'b0;
    refill[i] = 1'b0;
    total++;
    if (busy[i] !== 1'b1 || shrt[i] !== 1'b0 || remain[i] !== a16) begin
      bad++;
      $display("FAIL load_accept inst=%0d amt=%0d got busy=%b short=%b rem=%0d want 1 0 %0d",
               i, amt, busy[i], shrt[i], remain[i], amt);
    end
    if (with_refill) for (int j = 0; j < 4; j++) minv[i][j] = initv[i][j];
    plan(i, amt);
    while (exp_q.size() > 0) begin
      if (poke && cyc == 0) begin
        chg = {<<{W'(50)}};
        load[i] = 1'b1;
        refill[i] = 1'b1;
      end
      @(posedge clk); #1;
      load[i] = 1'b0;
      refill[i] = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      if (done[i] === 1'b1 && done_at < 0) done_at = cyc;
      total++;
      if (coin[i] !== e.coin || busy[i] !== e.busy || done[i] !== e.done ||
          shrt[i] !== e.shrt || remain[i] !== e.rem || empty[i] !== e.empty) begin
        bad++;
        $display("FAIL payout inst=%0d amt=%0d cyc=%0d got coin=%b busy=%b done=%b short=%b rem=%0d empty=%b want coin=%b busy=%b done=%b short=%b rem=%0d empty=%b",
                 i, amt, cyc, coin[i], busy[i], done[i], shrt[i], remain[i], empty[i],
                 e.coin, e.busy, e.done, e.shrt, e.rem, e.empty);
      end
    end
    @(posedge clk); #1;
    total++;
    if (done[i] !== 1'b0 || busy[i] !== 1'b0 || coin[i] !== 4'b0) begin
      bad++;
      $display("FAIL idle_after inst=%0d got done=%b busy=%b coin=%b want 0 0 0000",
               i, done[i], busy[i], coin[i]);
    end
  endtask

  task automatic test_reset();
    int d;
    for (int c = 0; c < 2; c++) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (coin[i] !== 4'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || shrt[i] !== 1'b0 ||
          remain[i] !== '0 || empty[i] !== model_empty(i)) begin
        bad++;
        $display("FAIL reset_state inst=%0d got coin=%b busy=%b done=%b short=%b rem=%0d empty=%b want empty=%b",
                 i, coin[i], busy[i], done[i], shrt[i], remain[i], empty[i], model_empty(i));
      end
    end
    // Abort a 1650 payout after two coins.
    @(negedge clk);
    chg = {<<{W'(1650)}};
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (coin[0] !== 4'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || remain[0] !== '0 ||
          empty[0] !== 4'b0) begin
        bad++;
        $display("FAIL reset_abort cyc=%0d got coin=%b busy=%b done=%b rem=%0d empty=%b want all 0",
                 c, coin[0], busy[0], done[0], remain[0], empty[0]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || coin[0] !== 4'b0) begin
        bad++;
        $display("FAIL reset_no_done cyc=%0d got done=%b busy=%b coin=%b want 0 0 0000",
                 c, done[0], busy[0], coin[0]);
      end
    end
    run_payout(0, 1650, 1'b0, 1'b0, d);
    total++;
    if (d !== 5) begin bad++; $display("FAIL reset_reload_done got=%0d want=5", d); end
  endtask

  task automatic test_basic();
    int d;
    run_payout(0, 1650, 1'b0, 1'b0, d);
    total++;
    if (d !== 5) begin bad++; $display("FAIL basic_done_at got=%0d want=5", d); end
    run_payout(0, 0, 1'b0, 1'b0, d);
    total++;
    if (d !== 1) begin bad++; $display("FAIL zero_done_at got=%0d want=1", d); end
    run_payout(0, 2850, 1'b0, 1'b0, d);
    total++;
    if (d !== 8) begin bad++; $display("FAIL mix_done_at got=%0d want=8", d); end
  endtask

  task automatic test_no500();
    int d;
    run_payout(1, 1500, 1'b0, 1'b0, d);
    total++;
    if (d !== 7 || empty[1][1] !== 1'b1) begin
      bad++;
      $display("FAIL no500 got done_at=%0d empty1=%b want 7 1", d, empty[1][1]);
    end
  endtask

  task automatic test_residue();
    int d;
    run_payout(0, 70, 1'b0, 1'b0, d);
    @(posedge clk); #1;
    total++;
    if (d !== 2 || shrt[0] !== 1'b1 || remain[0] !== W'(20)) begin
      bad++;
      $display("FAIL residue got done_at=%0d short=%b rem=%0d want 2 1 20", d, shrt[0], remain[0]);
    end
    run_payout(0, 100, 1'b0, 1'b0, d);
    total++;
    if (shrt[0] !== 1'b0 || remain[0] !== '0) begin
      bad++;
      $display("FAIL residue_clear got short=%b rem=%0d want 0 0", shrt[0], remain[0]);
    end
  endtask

  task automatic test_inventory();
    int d;
    run_payout(2, 150, 1'b1, 1'b0, d);
    run_payout(2, 150, 1'b0, 1'b0, d);
    run_payout(2, 150, 1'b0, 1'b0, d);
    total++;
    if (shrt[2] !== 1'b1 || remain[2] !== W'(50) || empty[2][3] !== 1'b1) begin
      bad++;
      $display("FAIL inv_short got short=%b rem=%0d empty3=%b want 1 50 1",
               shrt[2], remain[2], empty[2][3]);
    end
    @(negedge clk);
    refill[2] = 1'b1;
    @(posedge clk); #1;
    refill[2] = 1'b0;
    for (int j = 0; j < 4; j++) minv[2][j] = initv[2][j];
    total++;
    if (empty[2][3] !== 1'b0) begin
      bad++;
      $display("FAIL refill got empty3=%b want 0", empty[2][3]);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    run_payout(2, 150, 1'b0, 1'b0, d);
    run_payout(2, 150, 1'b0, 1'b0, d);
    run_payout(2, 150, 1'b0, 1'b1, d);
    total++;
    if (shrt[2] !== 1'b0 || d !== 3) begin
      bad++;
      $display("FAIL load_with_refill got short=%b done_at=%0d want 0 3", shrt[2], d);
    end
  endtask

  initial begin
    rst = 1'b1;
    chg = '0;
    load = '0;
    refill = '0;
    model_reset();
    test_reset();
    test_basic();
    test_no500();
    test_residue();
    test_inventory();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
